duck_score_counter: RTL and testbench
=====================================

Name: duck_score_counter

Overview:
- Score and ammo bookkeeping for one Duck Hunt game.
- Converts hit and shot events from the gun/target logic into a saturating 0..99 score, a shots-remaining count and game state.
- `score` drives the two-digit seven-segment decoder directly downstream. That decoder splits an 8-bit binary value into tens and ones, so `score` never exceeds 99.

Parameters:
- MAX_SCORE, 99, saturation ceiling for score; legal range 1..99.
- HIT_POINTS, 1, points added per hit; legal range 1..MAX_SCORE.
- SHOTS_PER_ROUND, 3, shots loaded at game start; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- game_start  input  1  level; its rising edge starts or restarts a game.
- shot  input  1  level, already synchronised and debounced; its rising edge is one trigger pull.
- hit  input  1  level, already synchronised; its rising edge is one duck hit.
- score  output  8  binary score, 0..MAX_SCORE, to the seven-segment decoder.
- shots_left  output  4  remaining shots.
- playing  output  1  high while in PLAY.
- game_over  output  1  high while in OVER.

Behaviour:
- All outputs and state are registered.
- Reset (rst_n low, asynchronous):
  - state=IDLE, score=0, shots_left=0, playing=0, game_over=0.
  - Edge-detect history registers for game_start, shot and hit reset to 1. An input held high through reset release therefore produces no edge.
- Edge detect: rise_x = x & ~x_prev, evaluated each clk; x_prev <= x every clk.
- Latency: an input first sampled high at clk edge N with x_prev=0 takes effect in registered outputs after edge N, i.e. one cycle. A held level counts once.
- FSM states: IDLE, PLAY, OVER.
- game_start rise, from any state, has priority over everything else that cycle:
  - score <= 0, shots_left <= SHOTS_PER_ROUND, state <= PLAY.
  - Same-cycle shot/hit edges are discarded.
- In PLAY, without game_start rise:
  - rise_hit: score <= min(score + HIT_POINTS, MAX_SCORE). Compute the sum at 9 bits so there is no wrap before the compare; once at MAX_SCORE, further hits hold the value.
  - rise_shot: shots_left <= shots_left - 1. If shots_left == 1, state <= OVER.
  - Same-cycle rise_hit and rise_shot: both apply. The hit counts even on the final shot; score updates in the same edge as the transition to OVER.
  - rise_shot with shots_left == 0 cannot occur in PLAY.
- In IDLE and OVER: rise_shot and rise_hit are ignored; score and shots_left hold.
- playing = (state==PLAY); game_over = (state==OVER). Both are registered and decoded from state.
- Reset mid-game: immediately returns to the reset values. The next game still requires a game_start rising edge.

Optional Feature:
- Macro: DUCK_HIGH_SCORE_EN.
- Defined:
  - Adds output port `high_score` (8 bits).
  - high_score resets to 0 on rst_n only; game_start does not clear it.
  - On the edge that enters OVER, if the final score (including any same-cycle hit) > high_score, then high_score <= final score. Otherwise it holds.
- Undefined: no high_score port and no register; all other behaviour is identical.

Test Plan:
- Reset release with hit=1 and shot=1 held, then game_start pulse → IDLE until the pulse; one cycle after it score=0, shots_left=3, playing=1, and no spurious hit or shot is counted.
- In PLAY, hit pulses 2 cycles wide ×4 → score steps 1,2,3,4, each one cycle after its rising edge; holding hit high 10 cycles adds exactly 1.
- MAX_SCORE=99, HIT_POINTS=7, 15 hits with SHOTS_PER_ROUND=15 → score reaches 98, then 99, then stays 99; score never exceeds 99.
- 3 shot pulses, with hit and shot rising in the same cycle on the third → score=1, shots_left=0, game_over=1 on that same edge; further hits leave score=1.
- Mid-game with score=5: game_start rising together with hit → score=0 (hit discarded) and shots_left=3. Separately, rst_n low mid-game → all outputs 0 asynchronously, before the next clk edge.
- DUCK_HIGH_SCORE_EN defined: game 1 ends at 4 → high_score=4; game 2 ends at 2 → high_score stays 4; game 3 ends at 6 → high_score=6; rst_n → high_score=0.

Source files
------------

// File: rtl/duck_score_counter.sv
// duck_score_counter: score and ammo bookkeeping for one Duck Hunt game.
// Latency: one clk from a sampled rising edge of game_start/shot/hit to the
// registered outputs. No backpressure: every input edge is consumed the cycle
// it is seen.
// Optional feature: define DUCK_HIGH_SCORE_EN to add the high_score output.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   game_start  level; rising edge starts or restarts a game
//   shot        level (synchronised, debounced); rising edge = one trigger pull
//   hit         level (synchronised); rising edge = one duck hit
//   score       binary score 0..MAX_SCORE, feeds the two-digit 7-seg decoder
//   shots_left  remaining shots in the current game
//   playing     high while a game is in progress
//   game_over   high once the last shot has been fired
//   high_score  (DUCK_HIGH_SCORE_EN only) best final score since reset
module duck_score_counter #(
  parameter int MAX_SCORE       = 99,
  parameter int HIT_POINTS      = 1,
  parameter int SHOTS_PER_ROUND = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       shot,
  input  logic       hit,
  output logic [7:0] score,
  output logic [3:0] shots_left,
  output logic       playing,
  output logic       game_over
`ifdef DUCK_HIGH_SCORE_EN
  ,
  output logic [7:0] high_score
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] OVER = 2'd2;

  localparam logic [7:0] MAX8   = 8'(MAX_SCORE);
  localparam logic [8:0] HIT9   = 9'(HIT_POINTS);
  localparam logic [3:0] SHOTS4 = 4'(SHOTS_PER_ROUND);

  logic [1:0] state, state_nxt;
  logic [7:0] score_nxt;
  logic [3:0] shots_nxt;

  // History registers reset high so a level held through reset release is
  // not mistaken for a fresh edge.
  logic start_prev, shot_prev, hit_prev;
  logic rise_start, rise_shot, rise_hit;

  assign rise_start = game_start & ~start_prev;
  assign rise_shot  = shot & ~shot_prev;
  assign rise_hit   = hit & ~hit_prev;

  // Sum at 9 bits so a score near 255 could never wrap before the compare.
  logic [8:0] sum9;
  logic [7:0] score_sat;
  assign sum9      = {1'b0, score} + HIT9;
  assign score_sat = (sum9 > {1'b0, MAX8}) ? MAX8 : sum9[7:0];

  always_comb begin
    state_nxt = state;
    score_nxt = score;
    shots_nxt = shots_left;
    if (rise_start) begin
      // Restart wins over any shot/hit edge in the same cycle.
      state_nxt = PLAY;
      score_nxt = 8'd0;
      shots_nxt = SHOTS4;
    end else if (state == PLAY) begin
      if (rise_hit) begin
        score_nxt = score_sat;
      end
      if (rise_shot) begin
        shots_nxt = shots_left - 4'd1;
        if (shots_left == 4'd1) begin
          state_nxt = OVER;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev <= 1'b1;
      shot_prev  <= 1'b1;
      hit_prev   <= 1'b1;
    end else begin
      start_prev <= game_start;
      shot_prev  <= shot;
      hit_prev   <= hit;
    end
  end

  // playing/game_over are registered copies of the next-state decode so they
  // line up exactly with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      score      <= 8'd0;
      shots_left <= 4'd0;
      playing    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= state_nxt;
      score      <= score_nxt;
      shots_left <= shots_nxt;
      playing    <= (state_nxt == PLAY);
      game_over  <= (state_nxt == OVER);
    end
  end

`ifdef DUCK_HIGH_SCORE_EN
  // Compare against score_nxt so a hit landing with the final shot counts.
  logic entering_over;
  assign entering_over = (state == PLAY) && (state_nxt == OVER);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_score <= 8'd0;
    end else if (entering_over && (score_nxt > high_score)) begin
      high_score <= score_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_duck_score_counter.sv
module tb_duck_score_counter;

  logic clk = 1'b0;
  logic rst_n;
  logic game_start, shot, hit;

  logic [7:0] a_score, b_score;
  logic [3:0] a_shots, b_shots;
  logic       a_playing, b_playing, a_over, b_over;
`ifdef DUCK_HIGH_SCORE_EN
  logic [7:0] a_high, b_high;
`endif

  always #5 clk = ~clk;

  // Instance A: default parameters. Instance B: coarse scoring, long round.
  duck_score_counter u_a (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .shot(shot), .hit(hit),
    .score(a_score), .shots_left(a_shots), .playing(a_playing), .game_over(a_over)
`ifdef DUCK_HIGH_SCORE_EN
    , .high_score(a_high)
`endif
  );

  duck_score_counter #(.MAX_SCORE(99), .HIT_POINTS(7), .SHOTS_PER_ROUND(15)) u_b (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .shot(shot), .hit(hit),
    .score(b_score), .shots_left(b_shots), .playing(b_playing), .game_over(b_over)
`ifdef DUCK_HIGH_SCORE_EN
    , .high_score(b_high)
`endif
  );

  // Reference model: game described as a phase string plus plain integers.
  typedef struct {
    string phase;   // "idle", "play", "over"
    int    score;
    int    shots;
    int    best;
    bit    last_start, last_shot, last_hit;
  } game_t;

  game_t ma, mb;
  int n_checks = 0;
  int n_errors = 0;

  function automatic game_t fresh();
    game_t g;
    g.phase = "idle"; g.score = 0; g.shots = 0; g.best = 0;
    g.last_start = 1; g.last_shot = 1; g.last_hit = 1;
    return g;
  endfunction

  function automatic game_t advance(game_t g, bit gs, bit sh, bit ht,
                                    int ceiling, int points, int load);
    game_t n = g;
    bit new_start = gs && !g.last_start;
    bit new_shot  = sh && !g.last_shot;
    bit new_hit   = ht && !g.last_hit;
    n.last_start = gs; n.last_shot = sh; n.last_hit = ht;
    if (new_start) begin
      n.phase = "play"; n.score = 0; n.shots = load;
    end else if (g.phase == "play") begin
      if (new_hit) n.score = (g.score + points > ceiling) ? ceiling : g.score + points;
      if (new_shot) begin
        n.shots = g.shots - 1;
        if (n.shots == 0) begin
          n.phase = "over";
          if (n.score > n.best) n.best = n.score;
        end
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_score", 32'(a_score), ma.score);
    chk("a_shots", 32'(a_shots), ma.shots);
    chk("a_playing", 32'(a_playing), 32'(ma.phase == "play"));
    chk("a_over", 32'(a_over), 32'(ma.phase == "over"));
    chk("b_score", 32'(b_score), mb.score);
    chk("b_shots", 32'(b_shots), mb.shots);
    chk("b_playing", 32'(b_playing), 32'(mb.phase == "play"));
    chk("b_over", 32'(b_over), 32'(mb.phase == "over"));
`ifdef DUCK_HIGH_SCORE_EN
    chk("a_high", 32'(a_high), ma.best);
    chk("b_high", 32'(b_high), mb.best);
`endif
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input bit gs, input bit sh, input bit ht);
    game_start = gs; shot = sh; hit = ht;
    @(posedge clk);
    if (rst_n) begin
      ma = advance(ma, gs, sh, ht, 99, 1, 3);
      mb = advance(mb, gs, sh, ht, 99, 7, 15);
    end
    @(negedge clk);
    check_all();
  endtask

  // Reset asserted between edges; outputs must clear before any clk edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    ma = fresh(); mb = fresh();
    #1 check_all();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  task automatic play_game(input int hits);
    cyc(1, 0, 0); cyc(0, 0, 0);
    repeat (hits) begin cyc(0, 0, 1); cyc(0, 0, 0); end
    repeat (3) begin cyc(0, 1, 0); cyc(0, 0, 0); end
  endtask

  initial begin
    rst_n = 1'b0; game_start = 1'b0; shot = 1'b1; hit = 1'b1;
    ma = fresh(); mb = fresh();
    @(negedge clk);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // hit/shot held high through reset release: no edges, stays idle.
    repeat (3) cyc(0, 1, 1);
    chk("idle_playing", 32'(a_playing), 0);
    cyc(1, 1, 1);
    chk("start_score", 32'(a_score), 0);
    chk("start_shots", 32'(a_shots), 3);
    chk("start_playing", 32'(a_playing), 1);
    cyc(0, 0, 0);

    // Four 2-cycle hit pulses, then hit held for 10 cycles.
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1);
      chk("hit_step", 32'(a_score), i);
      cyc(0, 0, 1); cyc(0, 0, 0);
    end
    repeat (10) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("held_hit", 32'(a_score), 5);

    // Restart together with a hit: hit discarded.
    cyc(1, 0, 1);
    chk("restart_score", 32'(a_score), 0);
    chk("restart_shots", 32'(a_shots), 3);
    cyc(0, 0, 0);

    // Three shots; hit and shot rise together on the last one.
    cyc(0, 1, 0); cyc(0, 0, 0);
    cyc(0, 1, 0); cyc(0, 0, 0);
    cyc(0, 1, 1);
    chk("final_score", 32'(a_score), 1);
    chk("final_shots", 32'(a_shots), 0);
    chk("final_over", 32'(a_over), 1);
    cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    chk("over_hold", 32'(a_score), 1);

    // Saturation on instance B: 7 points per hit, ceiling 99.
    cyc(1, 0, 0); cyc(0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      cyc(0, 0, 1);
      if (i == 14) chk("sat_98", 32'(b_score), 98);
      if (i >= 15) chk("sat_99", 32'(b_score), 99);
      cyc(0, 0, 0);
    end

    // Three games for high-score tracking, then reset clears it.
    play_game(4);
`ifdef DUCK_HIGH_SCORE_EN
    chk("high_g1", 32'(a_high), 4);
`endif
    play_game(2);
`ifdef DUCK_HIGH_SCORE_EN
    chk("high_g2", 32'(a_high), 4);
`endif
    play_game(6);
`ifdef DUCK_HIGH_SCORE_EN
    chk("high_g3", 32'(a_high), 6);
`endif

    // Mid-game asynchronous reset.
    cyc(1, 0, 0); cyc(0, 0, 0); cyc(0, 0, 1); cyc(0, 0, 0);
    async_reset();
    chk("rst_score", 32'(a_score), 0);
    cyc(0, 0, 1); cyc(0, 0, 0);
    chk("rst_needs_start", 32'(a_playing), 0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        async_reset();
      end else begin
        cyc($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 1) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
